// File: rtl/cordic_pkg.sv
// Shared constants and FSM encoding for the CORDIC datapath blocks.
package cordic_pkg;

  // Data/angle width and iteration count; values are Q3.(N-3)
  localparam int unsigned CordicN    = 32;
  localparam int unsigned CordicIter = 20;
  localparam int unsigned FracBits   = CordicN - 3;

  // pi in Q3.29
  localparam logic signed [CordicN-1:0] PiConst = 32'sh6487ED51;
  // Uncompensated CORDIC gain for 20 iterations, 1.646760258 in Q3.29
  localparam logic signed [CordicN-1:0] KGain   = 32'sd884097682;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } cordic_state_e;

endpackage

// File: rtl/arctan_lookup.sv
// Combinational arctan(2^-i) table in Q3.29, one entry per CORDIC iteration.
module arctan_lookup #(
  parameter int unsigned N = 32,
  parameter int unsigned I = 20
) (
  input  logic [$clog2(I)-1:0] idx,
  output logic [N-1:0]         atan
);

  // Entries are round(atan(2^-i) * 2^29); beyond the table the result is zero
  always_comb begin
    atan = '0;
    unique case (idx)
      5'd0:    atan = N'(32'd421657428);
      5'd1:    atan = N'(32'd248918915);
      5'd2:    atan = N'(32'd131521918);
      5'd3:    atan = N'(32'd66762579);
      5'd4:    atan = N'(32'd33510843);
      5'd5:    atan = N'(32'd16771758);
      5'd6:    atan = N'(32'd8387925);
      5'd7:    atan = N'(32'd4194219);
      5'd8:    atan = N'(32'd2097141);
      5'd9:    atan = N'(32'd1048575);
      5'd10:   atan = N'(32'd524288);
      5'd11:   atan = N'(32'd262144);
      5'd12:   atan = N'(32'd131072);
      5'd13:   atan = N'(32'd65536);
      5'd14:   atan = N'(32'd32768);
      5'd15:   atan = N'(32'd16384);
      5'd16:   atan = N'(32'd8192);
      5'd17:   atan = N'(32'd4096);
      5'd18:   atan = N'(32'd2048);
      5'd19:   atan = N'(32'd1024);
      default: atan = '0;
    endcase
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (atan2(y, x), K*|(x, y)|).
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int unsigned N = CordicN,
  parameter int unsigned I = CordicIter
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] angle_out,
  output logic [N-1:0] mag_out
);

  localparam int unsigned IdxW = $clog2(I);

  cordic_state_e         state_q;
  logic [IdxW-1:0]       iter_q;
  logic                  zero_q;
  logic signed [N-1:0]   x_q, y_q, z_q;
  logic signed [N-1:0]   x_sh, y_sh;
  logic signed [N-1:0]   x_nxt, y_nxt, z_nxt;
  logic [N-1:0]          atan_val;

  arctan_lookup #(
    .N (N),
    .I (I)
  ) u_arctan_lookup (
    .idx  (iter_q),
    .atan (atan_val)
  );

  // in_ready is held low during reset so nothing is accepted on a reset edge
  assign in_ready = rst_n && (state_q == StIdle);

  // One micro-rotation driving y towards zero; all updates use the old x and y
  always_comb begin
    x_sh = x_q >>> iter_q;
    y_sh = y_q >>> iter_q;
    if (!y_q[N-1]) begin
      x_nxt = x_q + y_sh;
      y_nxt = y_q - x_sh;
      z_nxt = z_q + $signed(atan_val);
    end else begin
      x_nxt = x_q - y_sh;
      y_nxt = y_q + x_sh;
      z_nxt = z_q - $signed(atan_val);
    end
  end

  // Control FSM, operand registers and registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      iter_q    <= '0;
      zero_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      out_valid <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            // Left half-plane: rotate by pi so the iterations see x >= 0
            if (x_in[N-1]) begin
              x_q <= -$signed(x_in);
              y_q <= -$signed(y_in);
              z_q <= y_in[N-1] ? -PiConst : PiConst;
            end else begin
              x_q <= $signed(x_in);
              y_q <= $signed(y_in);
              z_q <= '0;
            end
            zero_q  <= (x_in == '0) && (y_in == '0);
            iter_q  <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          z_q <= z_nxt;
          if (iter_q == IdxW'(I - 1)) begin
            // atan2(0, 0) is undefined; report a clean zero instead
            angle_out <= zero_q ? '0 : z_nxt;
            mag_out   <= zero_q ? '0 : x_nxt;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            iter_q <= iter_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed self-checking bench for cordic_vectoring.
module tb_cordic_vectoring;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] angle_out;
  logic [31:0] mag_out;

  int errors = 0;
  int checks = 0;

  cordic_vectoring dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle_out (angle_out),
    .mag_out   (mag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [31:0] y;
    longint      ang;
    longint      tol_a;
    longint      mag;
    longint      tol_m;
  } vec_t;

  vec_t vecs[6];

  function automatic longint absdiff(input longint a, input longint b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input longint act, input longint exp,
                            input longint tol);
    check(name, absdiff(act, exp) <= tol, act, exp);
  endtask

  // Accept one pair, wait (bounded) for the result, check latency and values, then release it
  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk);
    check({v.name, " in_ready idle"}, in_ready == 1'b1, longint'(in_ready), 1);
    in_valid = 1'b1;
    x_in     = v.x;
    y_in     = v.y;
    @(negedge clk);
    in_valid = 1'b0;
    x_in     = 32'h7FFF_FFFF;
    y_in     = 32'h7FFF_FFFF;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) check({v.name, " in_ready busy"}, in_ready == 1'b0, longint'(in_ready), 0);
    end
    check({v.name, " latency"}, cyc == 20, longint'(cyc), 20);
    check_near({v.name, " angle"}, longint'($signed(angle_out)), v.ang, v.tol_a);
    check_near({v.name, " mag"}, longint'($signed(mag_out)), v.mag, v.tol_m);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({v.name, " out_valid drop"}, out_valid == 1'b0, longint'(out_valid), 0);
    check({v.name, " in_ready back"}, in_ready == 1'b1, longint'(in_ready), 1);
  endtask

  initial begin
    logic [31:0] held_a;
    logic [31:0] held_m;
    int          cyc;
    bit          stable;
    bit          rose;

    //          name         x             y             angle         tol   mag         tol
    vecs[0] = '{"x_pos",     32'h1000_0000, 32'h0000_0000, 0,           2048, 442048841, 4096};
    vecs[1] = '{"diag",      32'h1000_0000, 32'h1000_0000, 421657428,   2048, 625151466, 4096};
    vecs[2] = '{"x_neg",     32'hF000_0000, 32'h0000_0000, 1686629713,  2048, 442048841, 4096};
    vecs[3] = '{"x_neg_ym1", 32'hF000_0000, 32'hFFFF_FFFF, -1686629713, 2048, 442048841, 4096};
    vecs[4] = '{"zero",      32'h0000_0000, 32'h0000_0000, 0,           0,    0,         0};
    vecs[5] = '{"y_neg",     32'h0000_0000, 32'hF800_0000, -843314857,  2048, 221024420, 4096};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst in_ready", in_ready == 1'b0, longint'(in_ready), 0);
    check("rst out_valid", out_valid == 1'b0, longint'(out_valid), 0);
    check("rst angle", angle_out == 32'd0, longint'(angle_out), 0);
    check("rst mag", mag_out == 32'd0, longint'(mag_out), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Back-pressure: hold out_ready low, pulse in_valid, outputs must not move
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 32'h1000_0000;
    y_in     = 32'h1000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("hold latency", cyc == 20, longint'(cyc), 20);
    held_a = angle_out;
    held_m = mag_out;
    check_near("hold angle", longint'($signed(held_a)), 421657428, 2048);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      x_in     = 32'h0800_0000;
      y_in     = 32'hF800_0000;
      @(negedge clk);
      if (!out_valid || angle_out != held_a || mag_out != held_m || in_ready) stable = 1'b0;
    end
    in_valid = 1'b0;
    check("hold stable", stable, longint'(stable), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold release valid", out_valid == 1'b0, longint'(out_valid), 0);
    check("hold release ready", in_ready == 1'b1, longint'(in_ready), 1);
    repeat (3) @(negedge clk);
    check("hold pulses ignored", in_ready == 1'b1 && !out_valid, longint'(in_ready), 1);

    // Reset in the middle of an operation aborts it
    in_valid = 1'b1;
    x_in     = 32'h1000_0000;
    y_in     = 32'h0000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("abort busy", in_ready == 1'b0, longint'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("abort ready in rst", in_ready == 1'b0, longint'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort angle", angle_out == 32'd0, longint'(angle_out), 0);
    check("abort mag", mag_out == 32'd0, longint'(mag_out), 0);
    @(negedge clk);
    check("abort ready after", in_ready == 1'b1, longint'(in_ready), 1);
    rose = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) rose = 1'b1;
    end
    check("abort no result", rose == 1'b0, longint'(rose), 0);

    // Engine still works after the abort
    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative CORDIC engine in vectoring mode. It converts a Cartesian pair (x, y) into a polar pair: an angle and a gain-scaled magnitude, which is the inverse of the rotation-mode direction. It consumes the shared arctan lookup table one entry per cycle. Inputs are accepted through a valid/ready handshake and results are held under a valid/ready handshake, so it sits between a sample source and downstream phase/magnitude consumers in the CORDIC datapath.

## Interface
- N, 32: data/angle width; all values signed two's-complement Q3.(N-3), so 1.0 = 2^29.
- I, 20: iteration count; lookup index width is $clog2(I).
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  **reset, synchronous, active-low**.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept; equals (state==IDLE).
- x_in  in  N  Cartesian x, range [-1.0, 1.0).
- y_in  in  N  Cartesian y, range [-1.0, 1.0).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- angle_out  out  N  atan2(y, x) in radians, range (-pi, +pi].
- mag_out  out  N  K·sqrt(x²+y²), where K = 1.646760258 for I=20 (gain is not compensated).

## Operation
- FSM states:
  - IDLE -> BUSY on in_valid & in_ready.
  - BUSY -> DONE after iteration I-1.
  - DONE -> IDLE on out_valid & out_ready.
- Accept (IDLE edge): register pre-rotated operands.
  - If x_in<0: x=-x_in, y=-y_in, z = y_in>=0 ? +PI : -PI.
  - Else: x=x_in, y=y_in, z=0.
  - Register zero flag = (x_in==0 && y_in==0); clear iteration counter i.
- BUSY, iteration i (0..I-1), table index j=i:
  - If y>=0: x+=y>>>i; y-=x>>>i; z+=atan[i].
  - Else: x-=y>>>i; y+=x>>>i; z-=atan[i].
  - All three updates use the old x and y.
- Arithmetic:
  - >>> is arithmetic shift (truncate toward -inf).
  - N-bit wraparound adders; no saturation.
  - With inputs in range, |x|≤2.33 and no overflow occurs.
- Entering DONE: angle_out=z, mag_out=x. If the zero flag is set, force angle_out=0 and mag_out=0.
- Out-of-range inputs (e.g. x_in=-4.0): results undefined, but the FSM must still complete and return to IDLE.
- PI constant = 1686629713 (0x6487ED51).

## Timing
- Reset (rst_n low at edge): state=IDLE, out_valid=0, angle_out=0, mag_out=0, counter=0.
- in_ready is 0 while rst_n is low and 1 in IDLE.
- Reset mid-BUSY or mid-DONE aborts the operation; no result is emitted.
- Latency:
  - Accept at edge t; iterations occupy edges t+1..t+I.
  - out_valid is high after edge t+I (20 cycles).
- DONE: angle_out, mag_out and out_valid stay stable until out_ready is sampled high.
- in_ready is 0 throughout BUSY and DONE; in_valid is ignored there.
- There is no same-cycle accept on the DONE->IDLE edge.
- Minimum spacing between accepts is I+2 cycles.
- Outputs are registered; in_ready is combinational from state only.

## Structure
- Shared package cordic_pkg holds:
  - N, Q-format fractional bit count, PI constant, K gain constant.
  - FSM state encoding (IDLE/BUSY/DONE).
- One sub-module: the existing arctan_lookup (N=32, I=20), addressed combinationally by the iteration counter.
- Everything else is flat in cordic_vectoring.

## Test plan
- x=0.5 (0x10000000), y=0 -> angle_out = 0 ±2048 LSB; mag_out = 0.82338·2^29 ±4096 LSB; out_valid exactly 20 cycles after accept.
- x=0.5, y=0.5 -> angle_out = 421657428 (pi/4) ±2048; mag_out = 1.16443·2^29 ±4096.
- x=-0.5, y=0 -> angle_out = +1686629713 ±2048. x=-0.5, y=-1 LSB -> angle_out ≈ -1686629713 ±2048.
- x=0, y=0 -> angle_out=0 and mag_out=0 exactly. x=0, y=-0.25 -> angle_out = -pi/2 (-843314857) ±2048.
- Hold out_ready low 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE and in_ready=1 next cycle.
- Assert rst_n=0 at iteration 10 -> out_valid never rises for that operation, outputs read 0, and in_ready=1 the cycle after rst_n returns high.
